ysyx_23060208_pcu: RTL and testbench

YSYX_23060208_PCU -- requirements
Module: ysyx_23060208_pcu

---
 rtl/ysyx_23060208_pkg.sv | 13 +
 rtl/ysyx_23060208_pcu_nextsel.sv | 38 +++
 rtl/ysyx_23060208_pcu.sv | 85 ++++++++
 tb/tb_ysyx_23060208_pcu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the program counter unit: FSM encoding and boot defaults.
package ysyx_23060208_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } pcu_state_e;

    localparam logic [31:0] DefResetVec  = 32'h8000_0000;
    localparam int unsigned DefInstBytes = 4;

endpackage

// File: rtl/ysyx_23060208_pcu_nextsel.sv
// Next-pc selection for the PCU: target alignment and halt > trap > redirect > increment > hold.
module ysyx_23060208_pcu_nextsel
    import ysyx_23060208_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_BYTES = DefInstBytes
) (
    input  logic                  halt,
    input  logic                  trap_valid,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  redir_valid,
    input  logic [DATA_WIDTH-1:0] redir_pc,
    input  logic                  fire,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  misalign_next
);

    localparam logic [DATA_WIDTH-1:0] AlignMask = DATA_WIDTH'(INST_BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] Step      = DATA_WIDTH'(INST_BYTES);

    always_comb begin
        pc_next       = pc;
        misalign_next = 1'b0;
        if (!halt) begin
            if (trap_valid) begin
                pc_next       = trap_pc & ~AlignMask;
                misalign_next = |(trap_pc & AlignMask);
            end else if (redir_valid) begin
                pc_next       = redir_pc & ~AlignMask;
                misalign_next = |(redir_pc & AlignMask);
            end else if (fire) begin
                pc_next = pc + Step;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060208_pcu.sv
// Program counter unit: BOOT/RUN/HALT FSM offering fetch addresses to the IFU via valid/ready.
module ysyx_23060208_pcu
    import ysyx_23060208_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VEC  = DATA_WIDTH'(DefResetVec),
    parameter int unsigned           INST_BYTES = DefInstBytes,
    parameter int unsigned           CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic                  redir_valid,
    input  logic [DATA_WIDTH-1:0] redir_pc,
    input  logic                  trap_valid,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  halt,
    output logic                  halted,
    output logic                  misalign,
    output logic [CNT_WIDTH-1:0]  fetch_cnt
);

    pcu_state_e            state;
    logic                  fire;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  misalign_next;

    // out_valid is registered to equal (state == StRun), so it doubles as the RUN flag.
    assign fire = out_valid & out_ready;

    ysyx_23060208_pcu_nextsel #(
        .DATA_WIDTH(DATA_WIDTH),
        .INST_BYTES(INST_BYTES)
    ) u_nextsel (
        .halt         (halt),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .fire         (fire),
        .pc           (pc),
        .pc_next      (pc_next),
        .misalign_next(misalign_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StBoot;
            pc        <= RESET_VEC;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            misalign  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            unique case (state)
                StBoot, StRun: begin
                    fetch_cnt <= fetch_cnt + CNT_WIDTH'(fire);
                    pc        <= pc_next;
                    misalign  <= misalign_next;
                    if (halt) begin
                        state     <= StHalt;
                        out_valid <= 1'b0;
                        halted    <= 1'b1;
                    end else begin
                        state     <= StRun;
                        out_valid <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                StHalt: begin
                    misalign <= 1'b0;
                end
                default: begin
                    state     <= StBoot;
                    out_valid <= 1'b0;
                    halted    <= 1'b0;
                    misalign  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_pcu.sv
// Self-checking bench for ysyx_23060208_pcu: directed scenarios plus randomized run vs a reference model.
module tb_ysyx_23060208_pcu;

    logic        clk = 1'b0;
    logic        rst, out_ready, redir_valid, trap_valid, halt;
    logic [31:0] redir_pc, trap_pc;
    logic        out_valid, halted, misalign;
    logic [31:0] pc, fetch_cnt;

    logic        rst8, ready8;
    logic        valid8, halted8, misalign8;
    logic [7:0]  pc8;
    logic [1:0]  cnt8;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: 0 = boot, 1 = run, 2 = halt
    int          m_state;
    logic [31:0] m_pc, m_cnt;
    logic        m_mis;

    always #5 clk = ~clk;

    ysyx_23060208_pcu dut (
        .clk        (clk),
        .rst        (rst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc         (pc),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .halt       (halt),
        .halted     (halted),
        .misalign   (misalign),
        .fetch_cnt  (fetch_cnt)
    );

    ysyx_23060208_pcu #(
        .DATA_WIDTH(8),
        .RESET_VEC (8'hF0),
        .INST_BYTES(4),
        .CNT_WIDTH (2)
    ) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .out_valid  (valid8),
        .out_ready  (ready8),
        .pc         (pc8),
        .redir_valid(1'b0),
        .redir_pc   (8'h00),
        .trap_valid (1'b0),
        .trap_pc    (8'h00),
        .halt       (1'b0),
        .halted     (halted8),
        .misalign   (misalign8),
        .fetch_cnt  (cnt8)
    );

    // Advance the reference model from the applied inputs, then step one clock.
    task automatic tick();
        logic accepted;
        if (rst) begin
            m_state = 0; m_pc = 32'h8000_0000; m_cnt = 0; m_mis = 0;
        end else if (m_state == 2) begin
            m_mis = 0;
        end else begin
            accepted = (m_state == 1) && out_ready;
            if (accepted) m_cnt = m_cnt + 1;
            m_mis = 0;
            if (halt) begin
                m_state = 2;
            end else begin
                m_state = 1;
                if (trap_valid) begin
                    m_pc  = {trap_pc[31:2], 2'b00};
                    m_mis = (trap_pc % 4) != 0;
                end else if (redir_valid) begin
                    m_pc  = {redir_pc[31:2], 2'b00};
                    m_mis = (redir_pc % 4) != 0;
                end else if (accepted) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; out_ready = 0; redir_valid = 0; trap_valid = 0; halt = 0;
        redir_pc = 0; trap_pc = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; out_ready = 1; redir_valid = 1; redir_pc = 32'h1234_5678; trap_valid = 1;
        tick(); tick();
        clear_inputs();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_vec++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_pc got %h want 80000000", pc); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %0b want 0", halted); end
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %0b want 0", misalign); end
        n_vec++; if (fetch_cnt !== 0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || pc !== exp_pc[i] || fetch_cnt !== 32'(i)) begin
                n_err++;
                $display("FAIL seq_%0d got v=%0b pc=%h cnt=%0d want v=1 pc=%h cnt=%0d",
                         i, out_valid, pc, fetch_cnt, exp_pc[i], i);
            end
        end
        tick();
        n_vec++; if (pc !== 32'h8000_0010) begin n_err++; $display("FAIL seq_pc got %h want 80000010", pc); end
    endtask

    task automatic test_stall();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || pc !== 32'h8000_0010 || fetch_cnt !== 32'd4) begin
                n_err++;
                $display("FAIL stall_%0d got v=%0b pc=%h cnt=%0d want v=1 pc=80000010 cnt=4",
                         i, out_valid, pc, fetch_cnt);
            end
        end
    endtask

    task automatic test_redirect();
        redir_valid = 1; redir_pc = 32'h8000_0100;
        tick();
        redir_valid = 0;
        n_vec++;
        if (pc !== 32'h8000_0100 || fetch_cnt !== 32'd4 || misalign !== 1'b0) begin
            n_err++;
            $display("FAIL redir_flush got pc=%h cnt=%0d mis=%0b want pc=80000100 cnt=4 mis=0",
                     pc, fetch_cnt, misalign);
        end
        // Redirect coinciding with a handshake still counts the handshake
        out_ready = 1; redir_valid = 1; redir_pc = 32'h8000_0300;
        tick();
        redir_valid = 0; out_ready = 0;
        n_vec++;
        if (pc !== 32'h8000_0300 || fetch_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL redir_fire got pc=%h cnt=%0d want pc=80000300 cnt=5", pc, fetch_cnt);
        end
    endtask

    task automatic test_priority();
        trap_valid = 1; trap_pc = 32'h8000_1000;
        redir_valid = 1; redir_pc = 32'h8000_0200;
        tick();
        trap_valid = 0; redir_valid = 0;
        n_vec++; if (pc !== 32'h8000_1000) begin n_err++; $display("FAIL trap_prio got %h want 80001000", pc); end
    endtask

    task automatic test_misalign();
        redir_valid = 1; redir_pc = 32'h8000_0102;
        tick();
        redir_valid = 0;
        n_vec++;
        if (pc !== 32'h8000_0100 || misalign !== 1'b1) begin
            n_err++;
            $display("FAIL mis_pulse got pc=%h mis=%0b want pc=80000100 mis=1", pc, misalign);
        end
        tick();
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear got %0b want 0", misalign); end
        trap_valid = 1; trap_pc = 32'h8000_2003;
        tick();
        trap_valid = 0;
        n_vec++;
        if (pc !== 32'h8000_2000 || misalign !== 1'b1) begin
            n_err++;
            $display("FAIL mis_trap got pc=%h mis=%0b want pc=80002000 mis=1", pc, misalign);
        end
        tick();
    endtask

    task automatic test_wrap8();
        logic [7:0] exp_pc [5] = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00};
        logic [1:0] exp_cnt [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst8 = 1; ready8 = 1;
        tick();
        rst8 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (valid8 !== 1'b1 || pc8 !== exp_pc[i] || cnt8 !== exp_cnt[i] || halted8 !== 1'b0 ||
                misalign8 !== 1'b0) begin
                n_err++;
                $display("FAIL wrap8_%0d got v=%0b pc=%h cnt=%0d want v=1 pc=%h cnt=%0d",
                         i, valid8, pc8, cnt8, exp_pc[i], exp_cnt[i]);
            end
        end
        ready8 = 0;
    endtask

    task automatic test_halt();
        logic [31:0] frozen_pc, frozen_cnt;
        frozen_pc = m_pc; frozen_cnt = m_cnt;
        halt = 1;
        tick();
        halt = 0;
        n_vec++;
        if (halted !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_enter got halted=%0b v=%0b want halted=1 v=0", halted, out_valid);
        end
        redir_valid = 1; redir_pc = 32'h8000_0400; trap_valid = 1; trap_pc = 32'h8000_0500;
        out_ready = 1;
        tick(); tick();
        redir_valid = 0; trap_valid = 0;
        n_vec++;
        if (pc !== frozen_pc || fetch_cnt !== frozen_cnt || halted !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_freeze got pc=%h cnt=%0d halted=%0b want pc=%h cnt=%0d halted=1",
                     pc, fetch_cnt, halted, frozen_pc, frozen_cnt);
        end
        rst = 1;
        tick();
        rst = 0;
        n_vec++;
        if (pc !== 32'h8000_0000 || halted !== 1'b0 || out_valid !== 1'b0 || fetch_cnt !== 0) begin
            n_err++;
            $display("FAIL halt_reset got pc=%h halted=%0b v=%0b cnt=%0d want 80000000/0/0/0",
                     pc, halted, out_valid, fetch_cnt);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || pc !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL boot_run got v=%0b pc=%h want v=1 pc=80000000", out_valid, pc);
        end
        // Reset mid-stall
        out_ready = 1; tick(); tick();
        out_ready = 0; tick();
        rst = 1; tick(); rst = 0;
        n_vec++;
        if (pc !== 32'h8000_0000 || fetch_cnt !== 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_reset got pc=%h cnt=%0d v=%0b want 80000000/0/0", pc, fetch_cnt, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            halt        = ($urandom_range(0, 39) == 0);
            trap_valid  = ($urandom_range(0, 9) == 0);
            redir_valid = ($urandom_range(0, 5) == 0);
            out_ready   = $urandom_range(0, 1) == 1;
            trap_pc     = $urandom();
            redir_pc    = $urandom();
            tick();
            n_vec++;
            if (out_valid !== (m_state == 1) || halted !== (m_state == 2) || pc !== m_pc ||
                fetch_cnt !== m_cnt || misalign !== m_mis) begin
                n_err++;
                $display("FAIL rand_%0d got v=%0b h=%0b pc=%h cnt=%0d mis=%0b want v=%0b h=%0b pc=%h cnt=%0d mis=%0b",
                         i, out_valid, halted, pc, fetch_cnt, misalign,
                         m_state == 1, m_state == 2, m_pc, m_cnt, m_mis);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst8 = 1; ready8 = 0;
        m_state = 0; m_pc = 32'h8000_0000; m_cnt = 0; m_mis = 0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_priority();
        test_misalign();
        test_wrap8();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
